// File: rtl/pipe_stage.sv
// Stallable, flushable pipeline boundary with valid/ready handshake and an optional
// two-entry skid buffer. Control bits read as zero whenever no entry is held.
module pipe_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [15:0]       stall_cycles_o
);

  // Encoding is {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [15:0]         stall_q, stall_d;

  logic main_valid, skid_valid, accept, consume;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  // With SKID=0 an accept in StOne always coincides with a consume, so StFull is unreachable.
  assign in_ready_o = ((SKID != 0) ? !skid_valid : (out_ready_i || !main_valid)) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign consume    = main_valid && out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else if (accept) begin
            state_d     = StFull;
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (consume) begin
            state_d     = StOne;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid_o    = main_valid;
  assign out_data_o     = main_data_q;
  assign out_ctrl_o     = main_valid ? main_ctrl_q : '0;
  assign occupancy_o    = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: SKID=1 and SKID=0 instances share stimulus, each checked
// against a queue-based FIFO model of the stage.
module tb_pipe_stage;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni, flush_i, in_valid_i, out_ready_i;
  logic [DW-1:0] in_data_i;
  logic [CW-1:0] in_ctrl_i;

  logic          rdy1, ov1, rdy0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;
  logic [15:0]   st1, st0;

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy1), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(ov1), .out_ready_i(out_ready_i), .out_data_o(od1), .out_ctrl_o(oc1),
    .occupancy_o(occ1), .stall_cycles_o(st1)
  );

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_noskid (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy0), .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(ov0), .out_ready_i(out_ready_i), .out_data_o(od0), .out_ctrl_o(oc0),
    .occupancy_o(occ0), .stall_cycles_o(st0)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: entries are {data, ctrl}; head_* is the last entry that reached the head.
  logic [DW+CW-1:0] q1[$];
  logic [DW+CW-1:0] q0[$];
  int               stall_m1, stall_m0;
  logic [DW-1:0]    head1, head0;
  bit               acc1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    stall_m1 = 0;
    stall_m0 = 0;
    head1    = '0;
    head0    = '0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_s1_valid", 64'(ov1), 64'd0);
    check_eq("rst_s1_ctrl", 64'(oc1), 64'd0);
    check_eq("rst_s1_data", od1, 64'd0);
    check_eq("rst_s1_occ", 64'(occ1), 64'd0);
    check_eq("rst_s1_stall", 64'(st1), 64'd0);
    check_eq("rst_s0_valid", 64'(ov0), 64'd0);
    check_eq("rst_s0_occ", 64'(occ0), 64'd0);
    check_eq("rst_s0_stall", 64'(st0), 64'd0);
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next one.
  task automatic step();
    bit er1, er0, ac0, cs1, cs0;
    int sz1, sz0;
    sz1 = q1.size();
    sz0 = q0.size();
    #1;
    er1 = (sz1 < 2) && !flush_i;
    er0 = (out_ready_i || sz0 == 0) && !flush_i;
    check_eq("s1_in_ready", 64'(rdy1), 64'(er1));
    check_eq("s1_out_valid", 64'(ov1), 64'(sz1 > 0));
    check_eq("s1_out_ctrl", 64'(oc1), (sz1 > 0) ? 64'(q1[0][CW-1:0]) : 64'd0);
    check_eq("s1_out_data", od1, (sz1 > 0) ? q1[0][DW+CW-1:CW] : head1);
    check_eq("s1_occupancy", 64'(occ1), 64'(sz1));
    check_eq("s1_stall", 64'(st1), 64'(stall_m1));
    check_eq("s0_in_ready", 64'(rdy0), 64'(er0));
    check_eq("s0_out_valid", 64'(ov0), 64'(sz0 > 0));
    check_eq("s0_out_ctrl", 64'(oc0), (sz0 > 0) ? 64'(q0[0][CW-1:0]) : 64'd0);
    check_eq("s0_out_data", od0, (sz0 > 0) ? q0[0][DW+CW-1:CW] : head0);
    check_eq("s0_occupancy", 64'(occ0), 64'(sz0));
    check_eq("s0_stall", 64'(st0), 64'(stall_m0));
    acc1 = in_valid_i && er1;
    ac0  = in_valid_i && er0;
    cs1  = (sz1 > 0) && out_ready_i;
    cs0  = (sz0 > 0) && out_ready_i;
    if (sz1 > 0 && !out_ready_i && stall_m1 < 65535) stall_m1++;
    if (sz0 > 0 && !out_ready_i && stall_m0 < 65535) stall_m0++;
    @(posedge clk_i);
    if (cs1) void'(q1.pop_front());
    if (cs0) void'(q0.pop_front());
    if (flush_i) begin
      q1.delete();
      q0.delete();
    end else begin
      if (acc1) q1.push_back({in_data_i, in_ctrl_i});
      if (ac0)  q0.push_back({in_data_i, in_ctrl_i});
    end
    if (q1.size() > 0) head1 = q1[0][DW+CW-1:CW];
    if (q0.size() > 0) head0 = q0[0][DW+CW-1:CW];
    @(negedge clk_i);
  endtask

  initial begin
    logic [DW-1:0] nxt;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_data_i   = '0;
    in_ctrl_i   = '0;
    model_reset();
    #1;
    check_reset_outputs();
    check_eq("rst_s1_in_ready", 64'(rdy1), 64'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Stream of 8 with downstream always ready.
    out_ready_i = 1'b1;
    in_ctrl_i   = 8'hA5;
    nxt         = 64'd1;
    for (int i = 0; i < 20 && nxt <= 64'd8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = nxt;
      step();
      if (acc1) nxt++;
    end
    in_valid_i = 1'b0;
    step();
    step();
    check_eq("stream_stall", 64'(st1), 64'd0);

    // Single-cycle out_ready drop mid-stream.
    in_valid_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out_ready_i = (i != 3);
      in_data_i   = nxt;
      step();
      if (acc1) nxt++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) step();
    check_eq("drop_stall", 64'(st1), 64'd1);

    // Long downstream stall with upstream pushing.
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 22; i++) begin
      in_data_i = nxt;
      step();
      if (acc1) nxt++;
    end
    check_eq("hold_occ", 64'(occ1), 64'd2);

    // Flush while FULL with a pending input.
    in_data_i = 64'hDEAD_BEEF;
    flush_i   = 1'b1;
    step();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    check_eq("flush_occ", 64'(occ1), 64'd0);
    repeat (2) step();

    // Asynchronous reset between edges while FULL.
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    in_data_i   = 64'h1234;
    step();
    in_data_i = 64'h5678;
    step();
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Stall counter saturation.
    in_valid_i  = 1'b1;
    in_data_i   = 64'hCAFE;
    step();
    in_valid_i = 1'b0;
    repeat (65540) @(posedge clk_i);
    @(negedge clk_i);
    if (q1.size() > 0) stall_m1 = (stall_m1 + 65540 > 65535) ? 65535 : stall_m1 + 65540;
    if (q0.size() > 0) stall_m0 = (stall_m0 + 65540 > 65535) ? 65535 : stall_m0 + 65540;
    step();
    step();
    check_eq("sat_stall", 64'(st1), 64'hFFFF);

    // Fresh reset, then randomized traffic.
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 19) == 0);
      in_data_i   = {$urandom, $urandom};
      in_ctrl_i   = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register, successor to the fixed-width stage latches between pipeline phases. It carries a data payload and a control bundle from one stage to the next with a valid/ready handshake. An optional two-entry skid buffer gives a fully registered `in_ready`. Synchronous flush inserts bubbles, and control bits are forced to zero whenever the stage holds no valid entry, so write enables (RegWrite, MemWrite, etc.) are never spuriously asserted. Instantiated between EX/MEM/WB and anywhere else the pipeline needs a stallable, flushable boundary.

## Interface
Parameters:
- `DATA_W`, default 64: payload width (ALU result, store data, operand copies, concatenated).
- `CTRL_W`, default 8: control bundle width (write enables, mux selects, destination register).
- `SKID`, default 1:
  - 1 = two-entry skid buffer with registered `in_ready`.
  - 0 = single register with combinational `in_ready`.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous. Discards all held entries at the next edge.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage accepts an entry this cycle.
- `in_data` in DATA_W: upstream payload.
- `in_ctrl` in CTRL_W: upstream control bundle.
- `out_valid` out 1: stage presents a valid entry.
- `out_ready` in 1: downstream consumes this cycle.
- `out_data` out DATA_W: payload of the head entry.
- `out_ctrl` out CTRL_W: control of the head entry. Forced to 0 when `out_valid`=0.
- `occupancy` out 2: number of held entries (0..2; max 1 when SKID=0).
- `stall_cycles` out 16: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Accept condition: `in_valid && in_ready`. Consume condition: `out_valid && out_ready`.
- Storage: a main register (head, drives outputs) and, when SKID=1, a skid register. Each register has its own valid bit.
- States, encoded by the valid bits: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid; SKID=1 only).
- Transitions, SKID=1:
  - EMPTY: accept -> ONE, main<=in.
  - ONE:
    - accept and consume -> ONE, main<=in.
    - accept only -> FULL, skid<=in.
    - consume only -> EMPTY.
    - neither -> ONE, hold.
  - FULL: no accept is possible. Consume -> ONE, main<=skid. Otherwise hold.
- `in_ready` (SKID=1) = !skid_valid && !flush. This is a register output gated only by `flush`.
- SKID=0:
  - `in_ready` = (out_ready || !main_valid) && !flush.
  - States are EMPTY and ONE only.
  - Accept loads main. Consume without accept -> EMPTY.
- Flush:
  - Highest priority. At the next edge both valid bits clear and the stage returns to EMPTY.
  - `in_ready` is 0 during the flush cycle, so no entry is accepted.
  - A consume in the flush cycle still counts as a completed transfer downstream.
  - Data registers need not clear.
- Bubble rule: `out_ctrl` = main_ctrl when main_valid, else all zeros. `out_data` is don't-care when invalid but must be stable (hold last value).
- Ordering: strict FIFO. The skid entry is always younger than main, and no entry is ever dropped or duplicated except by flush.
- `occupancy` = main_valid + skid_valid.
- `stall_cycles`:
  - Increments each cycle with `out_valid && !out_ready`.
  - Saturates at 16'hFFFF. It is not cleared by flush, only by reset.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` after edge N, i.e. one cycle.
- Throughput: one entry per cycle in steady state for both SKID values.
- SKID=1: a single-cycle `out_ready` drop causes no upstream bubble. The skid absorbs the entry, and `in_ready` falls one cycle later.
- SKID=1: after FULL drains to ONE, `in_ready` returns to 1 in the cycle following the consume.
- Reset (rst=0, asynchronous, immediate):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `stall_cycles`=0.
  - All valid bits 0. `in_ready`=1 once `flush` is 0.
- Reset deassertion: first accept possible at the first rising edge after `rst` goes high.
- Reset mid-transfer: held entries are lost. Upstream must treat reset as a global flush.
- Simultaneous accept and consume in ONE: a pass-through replacement with no occupancy change.
- Simultaneous flush and accept: the input is not accepted (`in_ready`=0).

## Test plan
- Reset, then stream 8 entries (data 0x1..0x8, ctrl 0xA5) with `out_ready`=1 -> each appears one cycle after accept, in order, `occupancy`=1 throughout, `stall_cycles`=0.
- SKID=1: stream with `out_ready` low for 1 cycle mid-stream -> `occupancy` goes 1->2->1, `in_ready` low exactly 1 cycle, no loss or duplication, `stall_cycles`=1.
- SKID=1: hold `out_ready`=0 for 20 cycles while `in_valid`=1 -> `occupancy` stays 2, `in_ready`=0, `out_data` constant, `stall_cycles`=19 or 20 matching cycles counted with `out_valid`=1.
- Assert `flush` in FULL with `in_valid`=1 -> next cycle `out_valid`=0, `out_ctrl`=0x00, `occupancy`=0, flushed input never appears at the output.
- SKID=0: toggle `out_ready` every cycle with continuous input -> `in_ready` equals `out_ready || !out_valid` combinationally, order preserved.
- Assert `rst`=0 asynchronously between edges while FULL -> outputs go to reset values immediately without waiting for a clock edge. Force `stall_cycles` past 0xFFFF -> it holds 0xFFFF.
